// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the asynchronous EN/MFC memory handshake.
// Optional STROBE watchdog enabled by defining MEM_TIMEOUT_EN (abort reported on err).
module mem_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err,
  output logic          busy,
  output logic          mem_EN,
  output logic          mem_RW,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_Data_in,
  input  logic [DW-1:0] mem_Data_out,
  input  logic          mem_MFC
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 gnt_q, gnt_d;
  logic                 mem_rw_q, mem_rw_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]        rdata0_q, rdata0_d;
  logic [DW-1:0]        rdata1_q, rdata1_d;
  logic                 abort_q, abort_d;
  logic [SYNC_STAGES-1:0] mfc_sync_q, mfc_sync_d;
  logic                 mfc_s;
  logic                 sel;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0]        cnt_q, cnt_d;
`endif

  // MFC is asynchronous to clk; only the last synchroniser stage is used.
  assign mfc_s = mfc_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    abort_d      = abort_q;
    mfc_sync_d   = {mfc_sync_q[SYNC_STAGES-2:0], mem_MFC};
    sel          = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Contended requests go to the port that did not win last time.
          sel         = (req0 && req1) ? ~last_grant_q : req1;
          gnt_d       = sel;
          mem_rw_d    = sel ? rw1    : rw0;
          mem_addr_d  = sel ? addr1  : addr0;
          mem_wdata_d = sel ? wdata1 : wdata0;
          abort_d     = 1'b0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (mfc_s) begin
          if (mem_rw_q) begin
            if (gnt_q) rdata1_d = mem_Data_out;
            else       rdata0_d = mem_Data_out;
          end
          state_d = S_RELEASE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (!mfc_s) state_d = S_DONE;
      end
      S_DONE: begin
        last_grant_d = gnt_q;
        mem_rw_d     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      mem_rw_q     <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      abort_q      <= 1'b0;
      mfc_sync_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      abort_q      <= abort_d;
      mfc_sync_q   <= mfc_sync_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Strobe and acks decode straight from the state flop so reset kills them immediately.
  assign mem_EN      = (state_q == S_STROBE);
  assign busy        = (state_q != S_IDLE);
  assign ack0        = (state_q == S_DONE) && !gnt_q;
  assign ack1        = (state_q == S_DONE) &&  gnt_q;
  assign mem_RW      = mem_rw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_Data_in = mem_wdata_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
`ifdef MEM_TIMEOUT_EN
  assign err         = (state_q == S_DONE) && abort_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared asynchronous-handshake memory (EN/RW/addr/Data_in/Data_out/MFC).
- Port 0 is instruction fetch; port 1 is the data load/store unit.
- Grants one request at a time using round-robin and drives the EN strobe. Waits for MFC to rise, then fall, and returns read data plus a one-cycle ack to the granted port.
- Sits between the CPU front end and the memory block. It is the only driver of the memory's EN/RW/addr/Data_in.

Parameters:
- AW, 16, address width
- DW, 16, data width
- SYNC_STAGES, 2, flops on mem_MFC before use (minimum 2)
- TIMEOUT, 64, cycles in STROBE before abort (only used with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req0  in  1  port 0 request; held high until ack0
- rw0  in  1  port 0 direction (1 = read, 0 = write)
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- ack0  out  1  one-cycle completion pulse
- rdata0  out  DW  read data, valid when ack0 = 1
- req1, rw1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- err  out  1  completion was aborted; valid with ack0/ack1
- busy  out  1  high in any state except IDLE
- mem_EN  out  1  memory strobe
- mem_RW  out  1  memory direction
- mem_addr  out  AW  memory address
- mem_Data_in  out  DW  memory write data
- mem_Data_out  in  DW  memory read data
- mem_MFC  in  1  memory function complete; asynchronous to clk, synchronised internally

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0 immediately, except mem_RW = 1. The FSM goes to IDLE and last_grant = 1, so port 0 wins first. A reset mid-transfer drops mem_EN at once and no ack is issued.
- IDLE:
  - If any reqN is high, pick the requester by round-robin. With both high, the grant goes to the port that is not last_grant. With one high, that port is granted.
  - Latch its rw/addr/wdata into mem_RW/mem_addr/mem_Data_in, then go to SETUP.
- SETUP (1 cycle): mem_EN = 0 and bus signals stable, giving setup before the strobe. Go to STROBE.
- STROBE: mem_EN = 1. Stay until the synchronised MFC is 1.
  - On that cycle, when mem_RW = 1, capture mem_Data_out into the granted port's rdata register. rdata of the other port is unchanged.
  - Go to RELEASE.
- RELEASE: mem_EN = 0. Stay until the synchronised MFC is 0, then go to DONE.
- DONE (1 cycle):
  - Pulse ackN for the granted port. err is driven in the same cycle.
  - Update last_grant, set mem_RW = 1, go to IDLE.
  - mem_addr and mem_Data_in hold their last values.
- Latency with no timeout: 1 (IDLE) + 1 (SETUP) + MFC-rise sync + 1 + MFC-fall sync + 1 (DONE).
  - With SYNC_STAGES = 2 and MFC rising within one cycle of EN, the minimum is 8 cycles from req to ack.
  - Back-to-back transfers are allowed: DONE → IDLE → next grant on the following cycle.
- reqN dropped before ack is a protocol violation. The transfer still completes and ack still pulses.
- rdata holds until that port's next read completes.
- Only one of ack0/ack1 is ever high. busy = (state != IDLE).
- A new request arriving during a transfer is held by the requester and considered in IDLE only.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to STROBE and increments each STROBE cycle.
  - If it reaches TIMEOUT-1 with no MFC, go to RELEASE with abort flag set and rdata not updated.
  - DONE then pulses ack with err = 1.
  - RELEASE waits for MFC low as normal.
- Undefined: no counter; STROBE waits forever; err is tied 0.

Test Plan:
- Reset, then req0 = 1, rw0 = 1, addr0 = 16'h0003, memory model returns 16'h0000 → mem_EN rises 2 cycles after req, ack0 pulses once, rdata0 = 16'h0000, err = 0, busy returns to 0.
- Port 1 write: req1 = 1, rw1 = 0, addr1 = 16'h0020, wdata1 = 16'hBEEF. Then port 1 read of 16'h0020 → mem_RW = 0 during the first strobe, ack1 twice, rdata1 = 16'hBEEF, rdata0 unchanged.
- req0 and req1 high continuously for 4 transfers → grant order 0, 1, 0, 1. ack0 and ack1 never high together.
- Assert reset in STROBE with mem_EN = 1 → mem_EN = 0 within the same delta, no ack. The next request completes normally.
- MFC delayed 20 cycles after EN → ack delayed to match, rdata correct. Latency equals 20 + the fixed overhead.
- With MEM_TIMEOUT_EN and TIMEOUT = 8, memory never raises MFC → mem_EN drops after 8 STROBE cycles, ack0 with err = 1, rdata0 unchanged. Without the macro, busy stays high.
